// File: rtl/layer_sequencer.sv
// Training-schedule controller: per sample, issues forward layer tokens 0..LAYER_MAX then
// backward tokens LAYER_MAX-1..0, one outstanding token at a time, each gated by its ack.
module layer_sequencer #(
    parameter int unsigned LAYER_ADDR_WIDTH = 2,
    parameter int unsigned LAYER_MAX        = 2,
    parameter int unsigned SAMPLE_WIDTH     = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SAMPLE_WIDTH-1:0]     num_samples,
    output logic [LAYER_ADDR_WIDTH-1:0] fw_layer_number,
    output logic                        fw_layer_number_valid,
    input  logic                        fw_layer_number_ready,
    output logic [LAYER_ADDR_WIDTH-1:0] bw_layer_number,
    output logic                        bw_layer_number_valid,
    input  logic                        bw_layer_number_ready,
    input  logic                        fw_ack,
    input  logic                        bw_ack,
    output logic                        busy,
    output logic                        done,
    output logic [SAMPLE_WIDTH-1:0]     samples_done,
    output logic                        protocol_error
);

    localparam logic [LAYER_ADDR_WIDTH-1:0] LAST_FW  = LAYER_ADDR_WIDTH'(LAYER_MAX);
    localparam logic [LAYER_ADDR_WIDTH-1:0] FIRST_BW = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_ONE = LAYER_ADDR_WIDTH'(1);
    localparam logic [SAMPLE_WIDTH-1:0]     SAMPLE_ONE = SAMPLE_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FW_ISSUE = 3'd1,
        FW_WAIT  = 3'd2,
        BW_ISSUE = 3'd3,
        BW_WAIT  = 3'd4,
        FINISH   = 3'd5
    } state_e;

    state_e                      state_q, state_d;
    logic [LAYER_ADDR_WIDTH-1:0] layer_q, layer_d;
    logic [SAMPLE_WIDTH-1:0]     count_q, count_d;
    logic [SAMPLE_WIDTH-1:0]     samples_q, samples_d;
    logic [SAMPLE_WIDTH-1:0]     sample_inc;
    logic [LAYER_ADDR_WIDTH-1:0] fw_tok_q, fw_tok_d;
    logic [LAYER_ADDR_WIDTH-1:0] bw_tok_q, bw_tok_d;
    logic                        fw_valid_q, fw_valid_d;
    logic                        bw_valid_q, bw_valid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        perr_q, perr_d;

    // State and registered outputs; async reset clears valids without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            layer_q    <= '0;
            count_q    <= '0;
            samples_q  <= '0;
            fw_tok_q   <= '0;
            bw_tok_q   <= '0;
            fw_valid_q <= 1'b0;
            bw_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            count_q    <= count_d;
            samples_q  <= samples_d;
            fw_tok_q   <= fw_tok_d;
            bw_tok_q   <= bw_tok_d;
            fw_valid_q <= fw_valid_d;
            bw_valid_q <= bw_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
        end
    end

    assign sample_inc = samples_q + SAMPLE_ONE;

    // Next-state logic; outputs are derived from the next state so they register with it.
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        count_d   = count_q;
        samples_d = samples_q;

        unique case (state_q)
            IDLE: begin
                if (start && (num_samples != '0)) begin
                    count_d   = num_samples;
                    layer_d   = '0;
                    samples_d = '0;
                    state_d   = FW_ISSUE;
                end
            end
            FW_ISSUE: begin
                if (fw_valid_q && fw_layer_number_ready) begin
                    state_d = FW_WAIT;
                end
            end
            FW_WAIT: begin
                if (fw_ack) begin
                    if (layer_q == LAST_FW) begin
                        layer_d = FIRST_BW;
                        state_d = BW_ISSUE;
                    end else begin
                        layer_d = layer_q + LAYER_ONE;
                        state_d = FW_ISSUE;
                    end
                end
            end
            BW_ISSUE: begin
                if (bw_valid_q && bw_layer_number_ready) begin
                    state_d = BW_WAIT;
                end
            end
            BW_WAIT: begin
                if (bw_ack) begin
                    if (layer_q == '0) begin
                        samples_d = sample_inc;
                        if (sample_inc == count_q) begin
                            state_d = FINISH;
                        end else begin
                            layer_d = '0;
                            state_d = FW_ISSUE;
                        end
                    end else begin
                        layer_d = layer_q - LAYER_ONE;
                        state_d = BW_ISSUE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fw_valid_d = (state_d == FW_ISSUE);
        bw_valid_d = (state_d == BW_ISSUE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FINISH);
        fw_tok_d   = (state_d == FW_ISSUE) ? layer_d : fw_tok_q;
        bw_tok_d   = (state_d == BW_ISSUE) ? layer_d : bw_tok_q;

        // An ack is only legal in its own WAIT state; the handshake cycle does not count.
        perr_d = perr_q
               | (fw_ack && (state_q != FW_WAIT))
               | (bw_ack && (state_q != BW_WAIT));
    end

    assign fw_layer_number       = fw_tok_q;
    assign fw_layer_number_valid = fw_valid_q;
    assign bw_layer_number       = bw_tok_q;
    assign bw_layer_number_valid = bw_valid_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign samples_done          = samples_q;
    assign protocol_error        = perr_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: token order, ack gating, backpressure, stray acks,
// ignored starts, reset behaviour and a full-count run.
module tb_layer_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] num_samples;
    logic [1:0] fw_layer_number;
    logic       fw_layer_number_valid;
    logic       fw_ready;
    logic [1:0] bw_layer_number;
    logic       bw_layer_number_valid;
    logic       bw_ready;
    logic       fw_ack;
    logic       bw_ack;
    logic       busy;
    logic       done;
    logic [9:0] samples_done;
    logic       protocol_error;

    int errors = 0;
    int checks = 0;
    int fw_log[$];
    int bw_log[$];
    int exp_fw[$];
    int exp_bw[$];
    int done_pulses;
    int acks_total;
    int acks_at_done;
    bit seen_done;
    bit both_valid;

    layer_sequencer #(
        .LAYER_ADDR_WIDTH(2),
        .LAYER_MAX       (2),
        .SAMPLE_WIDTH    (10)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .num_samples          (num_samples),
        .fw_layer_number      (fw_layer_number),
        .fw_layer_number_valid(fw_layer_number_valid),
        .fw_layer_number_ready(fw_ready),
        .bw_layer_number      (bw_layer_number),
        .bw_layer_number_valid(bw_layer_number_valid),
        .bw_layer_number_ready(bw_ready),
        .fw_ack               (fw_ack),
        .bw_ack               (bw_ack),
        .busy                 (busy),
        .done                 (done),
        .samples_done         (samples_done),
        .protocol_error       (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written token order for LAYER_MAX=2: forward 0,1,2 then backward 1,0.
    function automatic void build_exp(input int n);
        exp_fw.delete();
        exp_bw.delete();
        for (int s = 0; s < n; s++) begin
            exp_fw.push_back(0); exp_fw.push_back(1); exp_fw.push_back(2);
            exp_bw.push_back(1); exp_bw.push_back(0);
        end
    endfunction

    function automatic int first_diff(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 9999;
        foreach (a[i]) if (a[i] != b[i]) return i;
        return -1;
    endfunction

    // Starts a run and plays the downstream side: ready, acks `dly` cycles after handshake.
    task automatic run(input int n, input int dly, input int bp_layer,
                       input bit stray_bw, input bit restart, input int max_cyc);
        int fw_cnt = 0;
        int bw_cnt = 0;
        int bp_cnt = 0;
        int post = 0;
        bit bp_done = 0;
        bit stray_done = 0;
        fw_log.delete(); bw_log.delete();
        done_pulses = 0; acks_total = 0; acks_at_done = -1;
        seen_done = 0; both_valid = 0;
        fw_ready = 1'b1; bw_ready = 1'b1;
        @(negedge clk); start = 1'b1; num_samples = 10'(n);
        @(negedge clk); start = 1'b0; num_samples = '0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL run_busy: busy=%0b expected 1", busy);
        end
        for (int cyc = 0; cyc < max_cyc && post < 3; cyc++) begin
            fw_ack = 1'b0; bw_ack = 1'b0;
            if (fw_cnt > 0) begin
                fw_cnt--;
                if (fw_cnt == 0) begin fw_ack = 1'b1; acks_total++; end
            end
            if (bw_cnt > 0) begin
                bw_cnt--;
                if (bw_cnt == 0) begin bw_ack = 1'b1; acks_total++; end
            end
            if (stray_bw && !stray_done && bw_cnt > 0) begin
                fw_ack = 1'b1; stray_done = 1;
            end
            if (restart && cyc == 4) begin start = 1'b1; num_samples = 10'd5; end
            else begin start = 1'b0; num_samples = '0; end
            if (restart && cyc == 5) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL restart_busy: busy=%0b expected 1", busy);
                end
            end
            if (done === 1'b1) begin
                done_pulses++;
                if (!seen_done) acks_at_done = acks_total;
                seen_done = 1;
            end
            if (seen_done) post++;
            if (fw_layer_number_valid && bw_layer_number_valid) both_valid = 1;
            if (bp_cnt > 0) begin
                checks++;
                if (fw_layer_number_valid !== 1'b1 || int'(fw_layer_number) != bp_layer) begin
                    errors++;
                    $display("FAIL backpressure_hold: valid=%0b token=%0d expected valid=1 token=%0d",
                             fw_layer_number_valid, fw_layer_number, bp_layer);
                end
                bp_cnt--;
                if (bp_cnt == 0) begin fw_ready = 1'b1; bp_done = 1; end
            end else if (!bp_done && bp_layer >= 0 && fw_layer_number_valid === 1'b1
                         && int'(fw_layer_number) == bp_layer) begin
                fw_ready = 1'b0; bp_cnt = 10;
            end
            if (fw_layer_number_valid === 1'b1 && fw_ready) begin
                fw_log.push_back(int'(fw_layer_number)); fw_cnt = dly;
            end
            if (bw_layer_number_valid === 1'b1 && bw_ready) begin
                bw_log.push_back(int'(bw_layer_number)); bw_cnt = dly;
            end
            @(negedge clk);
        end
        fw_ack = 1'b0; bw_ack = 1'b0; start = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++; $display("FAIL run_timeout: done=0 after %0d cycles expected done=1", max_cyc);
        end
        checks++;
        if (both_valid) begin
            errors++; $display("FAIL one_outstanding: both valids high at once, expected never");
        end
    endtask

    task automatic check_streams(input string name, input int n);
        int d;
        build_exp(n);
        d = first_diff(fw_log, exp_fw);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL %s_fw_tokens: got %0d tokens (diff at %0d) expected %0d tokens",
                     name, fw_log.size(), d, exp_fw.size());
        end
        d = first_diff(bw_log, exp_bw);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL %s_bw_tokens: got %0d tokens (diff at %0d) expected %0d tokens",
                     name, bw_log.size(), d, exp_bw.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; num_samples = '0;
        fw_ready = 1'b1; bw_ready = 1'b1; fw_ack = 1'b0; bw_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({fw_layer_number_valid, bw_layer_number_valid, busy, done, protocol_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: fwv/bwv/busy/done/perr=%b expected 00000",
                     {fw_layer_number_valid, bw_layer_number_valid, busy, done, protocol_error});
        end
        checks++;
        if ({fw_layer_number, bw_layer_number, samples_done} !== 14'b0) begin
            errors++;
            $display("FAIL reset_values: fw=%0d bw=%0d samples=%0d expected 0 0 0",
                     fw_layer_number, bw_layer_number, samples_done);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        run(1, 3, -1, 0, 0, 200);
        check_streams("single", 1);
        checks++;
        if (done_pulses != 1) begin
            errors++; $display("FAIL single_done_pulses: got %0d expected 1", done_pulses);
        end
        checks++;
        if (samples_done !== 10'd1) begin
            errors++; $display("FAIL single_samples: got %0d expected 1", samples_done);
        end
        checks++;
        if (protocol_error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: perr=%0b busy=%0b expected 0 0", protocol_error, busy);
        end
    endtask

    task automatic test_multi();
        run(3, 3, -1, 0, 0, 600);
        check_streams("multi", 3);
        checks++;
        if (acks_at_done != 15) begin
            errors++; $display("FAIL multi_acks_at_done: got %0d expected 15", acks_at_done);
        end
        checks++;
        if (done_pulses != 1 || samples_done !== 10'd3) begin
            errors++;
            $display("FAIL multi_done: pulses=%0d samples=%0d expected 1 3", done_pulses, samples_done);
        end
    endtask

    task automatic test_backpressure();
        run(1, 3, 1, 0, 0, 300);
        check_streams("backpressure", 1);
        checks++;
        if (samples_done !== 10'd1 || protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_end: samples=%0d perr=%0b expected 1 0",
                     samples_done, protocol_error);
        end
    endtask

    task automatic test_ignored_start();
        @(negedge clk); start = 1'b1; num_samples = '0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b0 || fw_layer_number_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_start: busy=%0b fwv=%0b expected 0 0", busy, fw_layer_number_valid);
            end
            @(negedge clk);
        end
        run(1, 2, -1, 0, 1, 300);
        check_streams("busy_start", 1);
        checks++;
        if (samples_done !== 10'd1) begin
            errors++; $display("FAIL busy_start_samples: got %0d expected 1", samples_done);
        end
    endtask

    task automatic test_stray_ack();
        @(negedge clk); fw_ack = 1'b1;
        @(negedge clk); fw_ack = 1'b0;
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++; $display("FAIL stray_idle: perr=%0b expected 1", protocol_error);
        end
        run(1, 3, -1, 1, 0, 300);
        check_streams("stray", 1);
        checks++;
        if (protocol_error !== 1'b1 || samples_done !== 10'd1) begin
            errors++;
            $display("FAIL stray_sticky: perr=%0b samples=%0d expected 1 1", protocol_error, samples_done);
        end
    endtask

    task automatic test_midrun_reset();
        fw_ready = 1'b0;
        @(negedge clk); start = 1'b1; num_samples = 10'd2;
        @(negedge clk); start = 1'b0;
        checks++;
        if (fw_layer_number_valid !== 1'b1) begin
            errors++; $display("FAIL midrun_valid: fwv=%0b expected 1", fw_layer_number_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (fw_layer_number_valid !== 1'b0) begin
            errors++; $display("FAIL reset_async: fwv=%0b expected 0", fw_layer_number_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1; fw_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, protocol_error, fw_layer_number_valid} !== 4'b0 || samples_done !== 10'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%0b done=%0b perr=%0b fwv=%0b samples=%0d expected all 0",
                     busy, done, protocol_error, fw_layer_number_valid, samples_done);
        end
        run(1, 1, -1, 0, 0, 200);
        check_streams("after_reset", 1);
    endtask

    task automatic test_full_count();
        run(1023, 1, -1, 0, 0, 30000);
        checks++;
        if (samples_done !== 10'd1023 || done_pulses != 1) begin
            errors++;
            $display("FAIL full_count: samples=%0d pulses=%0d expected 1023 1", samples_done, done_pulses);
        end
        checks++;
        if (fw_log.size() != 3069 || bw_log.size() != 2046) begin
            errors++;
            $display("FAIL full_count_tokens: fw=%0d bw=%0d expected 3069 2046",
                     fw_log.size(), bw_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_ignored_start();
        test_full_count();
        test_stray_ack();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
